mmap_job_sequencer: RTL and testbench
=====================================

Name: mmap_job_sequencer

Overview:
Sequences one conv2d job through the shared dual-port memory. It polls the control word at CTRL_ADDR over port A. When the start bit is set, it loads N_CFG configuration words into registers and marks the job busy over port B. It then launches the engine with a start/done handshake and writes completion or error status back to the control word. It sits between the dual_port_memory host-visible window and the conv2d engine, replacing ad-hoc start polling.

Parameters:
ADDR_WIDTH, 10, memory address width
DATA_WIDTH, 32, memory word width
CTRL_ADDR, 0, control/status word address; config words at CTRL_ADDR+1 .. CTRL_ADDR+N_CFG
N_CFG, 7, number of configuration words (1..15)
POLL_GAP, 4, idle cycles between control-word polls (>=1)
TIMEOUT_CYCLES, 65535, max RUN cycles before abort (16-bit counter)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
o_addr0  out  ADDR_WIDTH  port A read address (registered)
i_data  in  DATA_WIDTH  port A read data, valid the cycle after o_addr0 is sampled by memory
o_addr1  out  ADDR_WIDTH  port B write address
o_we  out  1  port B write strobe (full-word write)
o_data  out  DATA_WIDTH  port B write data
o_cfg  out  N_CFG*DATA_WIDTH  config words; word k at bits [k*DW +: DW]
o_start  out  1  one-cycle engine launch pulse
i_done  in  1  engine completion pulse/level
o_busy  out  1  high from LOAD through STATUS
o_irq  out  1  one-cycle pulse when status is written
o_error  out  1  sticky timeout flag; cleared at next job start

Behaviour:
- CTRL word bits: [0] START, [1] BUSY, [2] DONE, [3] ERROR; [31:4] are written as 0.
- Reset values: o_addr0=CTRL_ADDR, o_addr1=CTRL_ADDR, o_we=0, o_data=0, o_cfg=0, o_start=0, o_busy=0, o_irq=0, o_error=0. State=IDLE, counters=0.
- States:
  - IDLE: count POLL_GAP cycles with o_addr0=CTRL_ADDR, then go to POLL.
  - POLL: wait 1 cycle for read latency, then go to CHECK.
  - CHECK: if i_data[0]=1, go to LOAD and set o_busy=1, o_error=0. Otherwise return to IDLE.
  - LOAD: pipelined. Address CTRL_ADDR+1+k is issued in LOAD cycle k. i_data is captured into cfg word k in cycle k+2, which covers address-register plus memory latency. LOAD lasts N_CFG+2 cycles and then goes to CLR.
  - CLR: one cycle with o_we=1, o_addr1=CTRL_ADDR, o_data=32'h2. Go to LAUNCH.
  - LAUNCH: o_start=1 for exactly one cycle; the timeout counter is cleared. Go to RUN.
  - RUN: i_done=1 goes to STATUS(ok). If the counter reaches TIMEOUT_CYCLES-1 without done, set o_error=1 and go to STATUS(err).
  - STATUS: one cycle with o_we=1, o_addr1=CTRL_ADDR, o_data=32'h4 (ok) or 32'h8 (err). o_irq=1 that cycle. Next cycle o_busy=0 and state=IDLE.
- o_cfg updates only in LOAD and stays stable from LAUNCH until the next job's LOAD.
- i_done is ignored outside RUN, including a done that coincides with the o_start cycle.
- Host writes to CTRL while BUSY is set are not observed; CLR or STATUS may overwrite them.
- A new START is detected only after STATUS, at the next poll. Back-to-back jobs are separated by at least POLL_GAP+2 cycles.
- o_we is never high outside CLR and STATUS; port A never reads during CLR or STATUS.
- Reset mid-job: all outputs return to reset values immediately (async). Memory contents are untouched, so CTRL may read BUSY=1 with START=0; the sequencer ignores BUSY and treats that word as idle.
- Timeout counter is 16 bits and saturates; it does not wrap.

Decomposition:
- Package mmap_seq_pkg: CTRL bit index constants, status word constants (CTRL_BUSY_WORD=32'h2, CTRL_DONE_WORD=32'h4, CTRL_ERR_WORD=32'h8), and the state encoding.
- One sub-module, seq_watchdog: a loadable saturating 16-bit counter with clear, enable and expired output, used for the RUN timeout.
- The rest is a single FSM plus the cfg register array.

Test Plan:
- Backdoor-write mem[1..7]=i*16000, then mem[0]=1. Required: o_cfg words equal 16000..112000 in order, one o_start pulse, mem[0]=32'h2 after CLR. Engine model pulses i_done 20 cycles later; required: mem[0]=32'h4, one o_irq pulse, o_busy falls.
- mem[0]=0 for 200 cycles. Required: no o_we, no o_start, o_addr0 stays CTRL_ADDR, o_busy=0.
- TIMEOUT_CYCLES=32 with i_done never asserted. Required: STATUS after 32 RUN cycles, mem[0]=32'h8, o_error=1. o_error clears at the next job's CHECK.
- i_done held high during LAUNCH and de-asserted before RUN. Required: no early completion; the job completes only on a later i_done.
- Assert i_rst mid-RUN. Required: all outputs at reset values the same cycle, mem[0] left at 32'h2, no o_start until a new START is written.
- Two jobs back-to-back: rewrite cfg and START right after the first o_irq. Required: second o_cfg reflects the new values and exactly two o_start pulses in total.

Source files
------------

// File: rtl/mmap_job_sequencer_pkg.sv
// Shared definitions for the memory-mapped job sequencer.
// - Control word bit positions (START/BUSY/DONE/ERROR).
// - Status words written back to the control word.
// - FSM state encoding.
package mmap_seq_pkg;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 1;
  localparam int CTRL_DONE_BIT  = 2;
  localparam int CTRL_ERR_BIT   = 3;

  // Only one status bit is ever set at a time; the upper bits are always zero.
  localparam logic [31:0] CTRL_BUSY_WORD = 32'(1) << CTRL_BUSY_BIT;
  localparam logic [31:0] CTRL_DONE_WORD = 32'(1) << CTRL_DONE_BIT;
  localparam logic [31:0] CTRL_ERR_WORD  = 32'(1) << CTRL_ERR_BIT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_CHECK,
    ST_LOAD,
    ST_CLR,
    ST_LAUNCH,
    ST_RUN,
    ST_STATUS
  } seq_state_t;

endpackage

// File: rtl/mmap_job_sequencer_if.sv
// Bus bundle between the sequencer, the dual-port memory window and the
// conv2d engine.
//   o_addr0 / i_data              : port A read address / read data
//   o_addr1 / o_we / o_data       : port B full-word write
//   o_cfg                         : configuration words (word k at [k*DW +: DW])
//   o_start / i_done              : engine launch / completion handshake
//   o_busy / o_irq / o_error      : job status toward the host
// master = sequencer side, slave = memory/engine/host side.
interface mmap_job_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int N_CFG      = 7
);
  logic [ADDR_WIDTH-1:0]       o_addr0;
  logic [DATA_WIDTH-1:0]       i_data;
  logic [ADDR_WIDTH-1:0]       o_addr1;
  logic                        o_we;
  logic [DATA_WIDTH-1:0]       o_data;
  logic [N_CFG*DATA_WIDTH-1:0] o_cfg;
  logic                        o_start;
  logic                        i_done;
  logic                        o_busy;
  logic                        o_irq;
  logic                        o_error;

  modport master (
    output o_addr0, o_addr1, o_we, o_data, o_cfg, o_start, o_busy, o_irq, o_error,
    input  i_data, i_done
  );

  modport slave (
    input  o_addr0, o_addr1, o_we, o_data, o_cfg, o_start, o_busy, o_irq, o_error,
    output i_data, i_done
  );
endinterface

// File: rtl/mmap_job_sequencer_watchdog.sv
// seq_watchdog: saturating up-counter used as the RUN timeout.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : count one per cycle while high; holds at all-ones
//   limit    : run-time loaded expiry threshold
//   expired  : count has reached limit
module seq_watchdog #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= limit);
endmodule

// File: rtl/mmap_job_sequencer.sv
// mmap_job_sequencer: runs one conv2d job through the shared dual-port memory.
// Polls the control word over port A; on START it loads N_CFG config words,
// marks the job BUSY over port B, launches the engine, and writes DONE or
// ERROR (timeout) back to the control word with a one-cycle irq.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : memory ports A/B, config words, engine handshake, status
module mmap_job_sequencer
  import mmap_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_ADDR      = 0,
  parameter int N_CFG          = 7,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  i_clk,
  input logic                  i_rst,
  mmap_job_sequencer_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] CTRL_A   = ADDR_WIDTH'(CTRL_ADDR);
  localparam logic [15:0]           WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  seq_state_t  state;
  logic [15:0] cnt;
  logic        wd_expired;

  // Timeout counter is zeroed during LAUNCH so RUN cycle j sees count j.
  seq_watchdog #(.CNT_W(16)) u_watchdog (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     (state == ST_LAUNCH),
    .en      (state == ST_RUN),
    .limit   (WD_LIMIT),
    .expired (wd_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bus.o_addr0 <= CTRL_A;
      bus.o_addr1 <= CTRL_A;
      bus.o_we    <= 1'b0;
      bus.o_data  <= '0;
      bus.o_cfg   <= '0;
      bus.o_start <= 1'b0;
      bus.o_busy  <= 1'b0;
      bus.o_irq   <= 1'b0;
      bus.o_error <= 1'b0;
    end else begin
      bus.o_we    <= 1'b0;
      bus.o_start <= 1'b0;
      bus.o_irq   <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.o_addr0 <= CTRL_A;
          if (cnt == 16'(POLL_GAP - 1)) begin
            cnt   <= '0;
            state <= ST_POLL;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_POLL: state <= ST_CHECK;
        ST_CHECK: begin
          cnt <= '0;
          // BUSY left over from an interrupted job is deliberately ignored.
          if (bus.i_data[CTRL_START_BIT]) begin
            bus.o_busy  <= 1'b1;
            bus.o_error <= 1'b0;
            state       <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // Address issued in cycle k reaches i_data in cycle k+2
          // (address register + memory read register).
          if (cnt < 16'(N_CFG)) begin
            bus.o_addr0 <= CTRL_A + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
          end else begin
            bus.o_addr0 <= CTRL_A;
          end
          for (int k = 0; k < N_CFG; k++) begin
            if (cnt == 16'(k + 2)) begin
              bus.o_cfg[k*DATA_WIDTH +: DATA_WIDTH] <= bus.i_data;
            end
          end
          if (cnt == 16'(N_CFG + 1)) begin
            cnt         <= '0;
            bus.o_we    <= 1'b1;
            bus.o_addr1 <= CTRL_A;
            bus.o_data  <= DATA_WIDTH'(CTRL_BUSY_WORD);
            state       <= ST_CLR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_CLR: begin
          bus.o_start <= 1'b1;
          state       <= ST_LAUNCH;
        end
        ST_LAUNCH: state <= ST_RUN;
        ST_RUN: begin
          // Completion wins if done arrives in the same cycle the timer expires.
          if (bus.i_done) begin
            bus.o_we    <= 1'b1;
            bus.o_irq   <= 1'b1;
            bus.o_addr1 <= CTRL_A;
            bus.o_data  <= DATA_WIDTH'(CTRL_DONE_WORD);
            state       <= ST_STATUS;
          end else if (wd_expired) begin
            bus.o_we    <= 1'b1;
            bus.o_irq   <= 1'b1;
            bus.o_error <= 1'b1;
            bus.o_addr1 <= CTRL_A;
            bus.o_data  <= DATA_WIDTH'(CTRL_ERR_WORD);
            state       <= ST_STATUS;
          end
        end
        ST_STATUS: begin
          bus.o_busy <= 1'b0;
          cnt        <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmap_job_sequencer.sv
module tb_mmap_job_sequencer;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int CTRL = 0;
  localparam int NC   = 7;
  localparam int GAP  = 4;
  localparam int TO   = 32;

  typedef struct packed {
    logic [NC*32-1:0] cfg;
    logic [31:0]      status;
    logic             err;
    logic [15:0]      lat;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] mem [0:1023];
  logic [31:0] rdata;
  logic        h_we;
  logic [AW-1:0] h_addr;
  logic [31:0] h_data;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_starts = 0;
  int exp_starts = 0;
  bit post_irq = 0;
  bit busy_prev = 0;
  logic [31:0] last_status = '0;
  exp_t sb[$];

  bit eng_never = 0;
  bit eng_glitch = 0;
  int eng_delay = 1;

  mmap_job_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CFG(NC)) bus ();

  mmap_job_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_ADDR(CTRL), .N_CFG(NC),
    .POLL_GAP(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Dual-port memory: synchronous read on port A, write on port B, host backdoor.
  always @(posedge clk) begin
    rdata <= mem[bus.o_addr0];
    if (bus.o_we) mem[bus.o_addr1] <= bus.o_data;
    if (h_we) mem[h_addr] <= h_data;
  end
  assign bus.i_data = rdata;
  assign bus.i_done = done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    @(negedge clk);
    h_we = 1; h_addr = AW'(a); h_data = d;
    @(negedge clk);
    h_we = 0;
  endtask

  // Engine: optional done glitch during LAUNCH, then done pulse eng_delay cycles later.
  initial begin
    done = 0;
    forever begin
      @(negedge clk);
      if (bus.o_start) begin
        if (eng_glitch) done = 1;
        @(negedge clk);
        done = 0;
        if (!eng_never) begin
          repeat (eng_delay - 1) @(negedge clk);
          done = 1;
          @(negedge clk);
          done = 0;
        end
      end
    end
  end

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (post_irq) begin
        chk("ctrl_after_status", mem[CTRL], last_status);
        chk("busy_after_status", 32'(bus.o_busy), 32'h0);
        post_irq = 0;
      end
      if (bus.o_busy && !busy_prev) chk("error_clear_on_start", 32'(bus.o_error), 32'h0);
      if (bus.o_we) chk("we_only_when_busy", 32'(bus.o_busy), 32'h1);
      if (bus.o_we && !bus.o_irq) begin
        chk("clr_data", bus.o_data, 32'h2);
        chk("clr_addr", 32'(bus.o_addr1), CTRL);
      end
      if (bus.o_start) begin
        n_starts++;
        chk("start_expected", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          for (int k = 0; k < NC; k++)
            chk($sformatf("cfg_word%0d", k), bus.o_cfg[k*32 +: 32], sb[0].cfg[k*32 +: 32]);
          chk("ctrl_busy_after_clr", mem[CTRL], 32'h2);
        end
        start_cyc = cyc;
      end
      if (bus.o_irq) begin
        chk("irq_expected", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("status_data", bus.o_data, e.status);
          chk("status_we", 32'(bus.o_we), 32'h1);
          chk("status_addr", 32'(bus.o_addr1), CTRL);
          chk("status_error", 32'(bus.o_error), 32'(e.err));
          chk("status_latency", 32'(cyc - start_cyc), 32'(e.lat));
          last_status = e.status;
          post_irq = 1;
        end
      end
    end
    busy_prev = bus.o_busy;
  end

  task automatic issue_job(input bit fixed, input bit never, input bit glitch, input int delay);
    exp_t e;
    logic [31:0] w;
    eng_never = never; eng_glitch = glitch; eng_delay = delay;
    e.cfg = '0;
    for (int k = 0; k < NC; k++) begin
      w = fixed ? 32'((k + 1) * 16000) : $urandom;
      e.cfg[k*32 +: 32] = w;
      host_write(CTRL + 1 + k, w);
    end
    e.status = never ? 32'h8 : 32'h4;
    e.err = never;
    e.lat = never ? 16'(TO + 1) : 16'(delay + 1);
    sb.push_back(e);
    exp_starts++;
    host_write(CTRL, 32'h1);
  endtask

  task automatic wait_irq(input string name);
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.o_irq) begin got = 1; break; end
    end
    chk(name, 32'(got), 32'h1);
  endtask

  task automatic wait_start(input string name);
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.o_start) begin got = 1; break; end
    end
    chk(name, 32'(got), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr0"}, 32'(bus.o_addr0), CTRL);
    chk({tag, "_addr1"}, 32'(bus.o_addr1), CTRL);
    chk({tag, "_we"}, 32'(bus.o_we), 32'h0);
    chk({tag, "_data"}, bus.o_data, 32'h0);
    for (int k = 0; k < NC; k++) chk({tag, "_cfg"}, bus.o_cfg[k*32 +: 32], 32'h0);
    chk({tag, "_start"}, 32'(bus.o_start), 32'h0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'h0);
    chk({tag, "_irq"}, 32'(bus.o_irq), 32'h0);
    chk({tag, "_error"}, 32'(bus.o_error), 32'h0);
  endtask

  initial begin
    rst = 1; h_we = 0; h_addr = '0; h_data = '0;
    repeat (2) @(negedge clk);
    host_write(CTRL, 32'h0);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 0;

    // Fixed configuration, engine completes 20 cycles after launch.
    issue_job(1, 0, 0, 20);
    wait_irq("job1_irq");

    // Idle: control word zero, nothing may happen.
    host_write(CTRL, 32'h0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_quiet", {29'h0, bus.o_we, bus.o_start, bus.o_busy}, 32'h0);
      chk("idle_addr0", 32'(bus.o_addr0), CTRL);
    end

    // Timeout: engine never responds.
    issue_job(0, 1, 0, 0);
    wait_irq("timeout_irq");
    repeat (3) @(negedge clk);
    chk("error_sticky", 32'(bus.o_error), 32'h1);

    // done asserted during LAUNCH only, real completion later.
    issue_job(0, 0, 1, $urandom_range(3, 25));
    wait_irq("glitch_irq");

    // Reset in the middle of RUN.
    issue_job(0, 1, 0, 0);
    wait_start("rst_job_start");
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1 check_reset_outputs("midrun_reset");
    sb.delete();
    @(negedge clk);
    rst = 0;
    chk("ctrl_after_reset", mem[CTRL], 32'h2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("stale_busy_ignored", {30'h0, bus.o_start, bus.o_busy}, 32'h0);
    end

    // Back-to-back jobs, second issued right after the first irq.
    issue_job(0, 0, 0, $urandom_range(1, 25));
    wait_irq("b2b1_irq");
    issue_job(0, 0, 0, $urandom_range(1, 25));
    wait_irq("b2b2_irq");

    // Randomized jobs.
    for (int j = 0; j < 4; j++) begin
      issue_job(0, 0, 1'($urandom_range(0, 1)), $urandom_range(1, 25));
      wait_irq("rand_irq");
    end

    repeat (5) @(negedge clk);
    chk("start_count", 32'(n_starts), 32'(exp_starts));
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    chk("final_busy", 32'(bus.o_busy), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
